// File: rtl/seq_turn_signal.sv
// Sequential turn-signal controller: left/right sweep and hazard flash on two
// lamp banks, stepped by an internal prescaler of TICK_DIV clock cycles.
module seq_turn_signal #(
  parameter int N_LIGHTS = 3,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                left,
  input  logic                right,
  input  logic                hazard,
  output logic [N_LIGHTS-1:0] left_lights,
  output logic [N_LIGHTS-1:0] right_lights,
  output logic                busy
);

  localparam int SW = $clog2(N_LIGHTS + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(N_LIGHTS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } mode_t;

  mode_t         mode_q, mode_d, req;
  logic [SW-1:0] step_q, step_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [N_LIGHTS-1:0] pattern;

  // IDLE doubles as "no request" for the prioritised request encoding.
  always_comb begin
    req = IDLE;
    if (hazard || (left && right)) req = HAZ;
    else if (left)                 req = LEFT;
    else if (right)                req = RIGHT;
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= IDLE;
      step_q <= '0;
      div_q  <= '0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      div_q  <= div_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    div_d  = div_q;
    if (mode_q == IDLE) begin
      div_d = '0;
      if (req != IDLE) begin
        mode_d = req;
        step_d = SW'(1);
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (req == IDLE) begin
          mode_d = IDLE;
          step_d = '0;
        end else if (req != mode_q) begin
          mode_d = req;
          step_d = SW'(1);
        end else if (mode_q == HAZ) begin
          step_d = (step_q == SW'(1)) ? '0 : SW'(1);
        end else begin
          step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
        end
      end
    end
  end

  // Top `step` lamps lit, MSB first; step==N_LIGHTS lights the whole bank.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      pattern[i] = (int'(step_q) > (N_LIGHTS - 1 - i));
    end
  end

  always_comb begin
    left_lights  = '0;
    right_lights = '0;
    unique case (mode_q)
      LEFT:    left_lights  = pattern;
      RIGHT:   right_lights = pattern;
      HAZ: begin
        left_lights  = (step_q == SW'(1)) ? '1 : '0;
        right_lights = (step_q == SW'(1)) ? '1 : '0;
      end
      default: ;
    endcase
  end

  assign busy = (mode_q != IDLE);

endmodule
